// File: rtl/seq_detect.sv
// seq_detect: serial bit-pattern detector.
//
// Bits are shifted into a W-bit window (oldest bit ends up at the MSB).
// Once W valid bits are held, every accepted bit is compared against the
// active pattern. A hit produces a registered one-cycle 'match' pulse and
// bumps a saturating match counter. Overlapping mode keeps the window
// primed after a hit. Non-overlapping mode discards it, so the next hit
// needs W fresh bits. The pattern and mode can only be reloaded while the
// detector is idle.

module seq_detect #(
    parameter int unsigned    W       = 4,
    parameter int unsigned    CNT_W   = 8,
    parameter logic [W-1:0]   DEF_PAT = 4'b1011,
    parameter bit             DEF_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             cfg_load,
    input  logic [W-1:0]     cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state
);

    // Fill counter must represent 0..W inclusive.
    localparam int unsigned     FW        = $clog2(W + 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(W);
    localparam logic [FW-1:0]   FILL_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Pattern lengths outside 2..16 are not supported.
    if (W < 2 || W > 16) begin : g_w_range
        $error("seq_detect: W must be in the range 2..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;

    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;
    logic [W-1:0]     window;
    logic [W-1:0]     window_nxt;
    logic [W-1:0]     active_pat;
    logic [W-1:0]     active_pat_nxt;
    logic             active_ovl;
    logic             active_ovl_nxt;
    logic             match_nxt;
    logic [CNT_W-1:0] match_cnt_nxt;
    logic             cnt_sat_nxt;

    // Candidate values if the current bit were accepted this cycle.
    logic [W-1:0]     shifted;
    logic [FW-1:0]    fill_inc;
    logic             accept;
    logic             hit;

    // Shift/fill candidates and the qualified accept/hit conditions.
    // NOTE: every signal driven from always_comb gets a default at the top of
    // the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        shifted  = {window[W-2:0], in_bit};
        fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
        accept   = 1'b0;
        hit      = 1'b0;
        if (en && !clr && in_valid && (cur_state != ST_IDLE)) begin
            accept = 1'b1;
            hit    = (fill_inc == FILL_FULL) && (shifted == active_pat);
        end
    end

    // Next-state, datapath and output decode; priority is en, then clr,
    // then leaving IDLE, then normal bit acceptance.
    always_comb begin
        nxt_state      = cur_state;
        fill_nxt       = fill;
        window_nxt     = window;
        active_pat_nxt = active_pat;
        active_ovl_nxt = active_ovl;
        match_nxt      = 1'b0;
        match_cnt_nxt  = match_cnt;
        cnt_sat_nxt    = cnt_sat;

        // Configuration is only honoured while idle, independent of en.
        if ((cur_state == ST_IDLE) && cfg_load) begin
            active_pat_nxt = cfg_pattern;
            active_ovl_nxt = cfg_overlap;
        end

        if (!en) begin
            nxt_state = ST_IDLE;
            fill_nxt  = '0;
        end else if (clr) begin
            // A bit presented alongside clr is dropped.
            nxt_state     = ST_FILL;
            fill_nxt      = '0;
            window_nxt    = '0;
            match_cnt_nxt = '0;
            cnt_sat_nxt   = 1'b0;
        end else if (cur_state == ST_IDLE) begin
            // The enabling edge only wakes the detector; no bit is taken.
            nxt_state = ST_FILL;
            fill_nxt  = '0;
        end else begin
            if (accept) begin
                window_nxt = shifted;
                fill_nxt   = fill_inc;
                if (hit) begin
                    match_nxt = 1'b1;
                    if (&match_cnt) begin
                        cnt_sat_nxt = 1'b1;
                    end else begin
                        match_cnt_nxt = match_cnt + CNT_ONE;
                    end
                    // Non-overlapping: the hit consumes the whole window.
                    if (!active_ovl) begin
                        fill_nxt = '0;
                    end
                end
            end
            nxt_state = (fill_nxt == FILL_FULL) ? ST_RUN : ST_FILL;
        end
    end

    // FSM state register.
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Window, fill, configuration and output registers.
    // NOTE: the window is a small register rather than a memory, so it is
    // reset along with everything else; a mid-stream reset must not leave
    // stale partial bits behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill       <= '0;
            window     <= '0;
            active_pat <= DEF_PAT;
            active_ovl <= DEF_OVL;
            match      <= 1'b0;
            match_cnt  <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            fill       <= fill_nxt;
            window     <= window_nxt;
            active_pat <= active_pat_nxt;
            active_ovl <= active_ovl_nxt;
            match      <= match_nxt;
            match_cnt  <= match_cnt_nxt;
            cnt_sat    <= cnt_sat_nxt;
        end
    end

    assign state = cur_state;

endmodule
